// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
//
// Responder side of the pipeline memory request interface. Serves
// instruction fetches and data reads/writes over one shared RAM port. Data
// requests win over instruction requests. Every served access ends with a
// one-cycle ihit or dhit pulse.
//
// Optional feature macro: MEM_ARB_TIMEOUT_EN
//   Defined   : an access that waits TIMEOUT_CYC cycles without ramrdy is
//               abandoned. The read target is loaded with all-ones, the
//               sticky err flag is set, and the hit still pulses.
//   Undefined : the arbiter waits for ramrdy indefinitely, and err is 0.
//
// Ports:
//   CLK, RST                   clock (rising edge), async active-high reset
//   iREN, iaddr                instruction request (level, held until ihit)
//   dREN, dWEN, daddr, dstore  data request (level, held until dhit)
//   ihit, iload                fetch done pulse; fetched word (held)
//   dhit, dload                data done pulse; loaded word (held)
//   ramREN, ramWEN             RAM read / write strobes (never both)
//   ramaddr, ramstore          RAM address / write data (registered)
//   ramload, ramrdy            RAM read data; access-done indication
//   err                        sticky timeout flag
// ---------------------------------------------------------------------------
module memory_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ramrdy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t r_state;
    logic   r_is_write;   // latched op of the data access in flight
    logic   w_timeout;    // abandon the current access this cycle

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] r_wait_cnt;

    // ramrdy on the last allowed cycle still completes normally.
    assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) && !ramrdy;
`else
    // The limit only matters when the timeout is compiled in.
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC != 0);
    assign w_timeout        = 1'b0;
    assign err              = 1'b0;
`endif

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every branch below sees the values from before this clock edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= IDLE;
            r_is_write <= 1'b0;
            ihit       <= 1'b0;
            dhit       <= 1'b0;
            ramREN     <= 1'b0;
            ramWEN     <= 1'b0;
            iload      <= '0;
            dload      <= '0;
            ramaddr    <= '0;
            ramstore   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_wait_cnt <= '0;
            err        <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    ihit <= 1'b0;
                    dhit <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                    if (dREN || dWEN) begin
                        // A simultaneous read and write is served as a write.
                        r_is_write <= dWEN;
                        ramaddr    <= daddr;
                        ramstore   <= dstore;
                        ramREN     <= !dWEN;
                        ramWEN     <= dWEN;
                        r_state    <= DACC;
                    end else if (iREN) begin
                        ramaddr <= iaddr;
                        ramREN  <= 1'b1;
                        ramWEN  <= 1'b0;
                        r_state <= IACC;
                    end
                end

                DACC, IACC: begin
                    if (ramrdy || w_timeout) begin
                        ramREN  <= 1'b0;
                        ramWEN  <= 1'b0;
                        r_state <= RESP;
                        if (r_state == IACC) begin
                            ihit  <= 1'b1;
                            iload <= w_timeout ? {DATA_W{1'b1}} : ramload;
                        end else begin
                            dhit <= 1'b1;
                            if (!r_is_write) begin
                                dload <= w_timeout ? {DATA_W{1'b1}} : ramload;
                            end
                        end
`ifdef MEM_ARB_TIMEOUT_EN
                        if (w_timeout) begin
                            err <= 1'b1;
                        end
`endif
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end

                // One response cycle, then back to IDLE unconditionally, so the
                // requester has one edge to drop its enable before resampling.
                RESP: begin
                    ihit    <= 1'b0;
                    dhit    <= 1'b0;
                    r_state <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_arbiter
//
// Self-checking bench for memory_arbiter. The bench plays both the CPU
// requester and the RAM. Each request is expanded into an ordered list of
// expected accesses (data first, then instruction). Every cycle of every
// access is checked: strobes, address, store data, hit pulses and load
// values.
// ---------------------------------------------------------------------------
module tb_memory_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 64;

    logic          CLK = 1'b0;
    logic          RST;
    logic          iREN, dREN, dWEN;
    logic [AW-1:0] iaddr, daddr;
    logic [DW-1:0] dstore;
    logic          ihit, dhit;
    logic [DW-1:0] iload, dload;
    logic          ramREN, ramWEN;
    logic [AW-1:0] ramaddr;
    logic [DW-1:0] ramstore;
    logic [DW-1:0] ramload;
    logic          ramrdy;
    logic          err;

    memory_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .ihit    (ihit),
        .iload   (iload),
        .dhit    (dhit),
        .dload   (dload),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramload (ramload),
        .ramrdy  (ramrdy),
        .err     (err)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Expected held load values.
    logic [DW-1:0] exp_iload = '0;
    logic [DW-1:0] exp_dload = '0;

    typedef struct {
        bit            is_i;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            k;       // RAM wait cycles before ramrdy
    } op_t;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Move to the middle (falling edge) of the next cycle.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic check_quiet(input string tag);
        check(tag, {60'd0, ramREN, ramWEN, ihit, dhit}, 64'd0);
    endtask

    // Present one request set while the DUT is in IDLE (called at a falling
    // edge), then follow every expected access to completion. force_k < 0
    // picks random RAM wait cycles.
    task automatic run_request(input bit want_i, input bit d_r, input bit d_w,
                               input logic [AW-1:0] ia, input logic [AW-1:0] da,
                               input logic [DW-1:0] ds, input int force_k);
        op_t           q[$];
        op_t           o;
        logic [DW-1:0] rd;
        iREN   = want_i;
        iaddr  = ia;
        dREN   = d_r;
        dWEN   = d_w;
        daddr  = da;
        dstore = ds;
        ramrdy = 1'($urandom_range(0, 1));   // ignored while idle
        if (d_r || d_w) begin
            o.is_i = 1'b0; o.wr = d_w; o.addr = da; o.wdata = ds;
            o.k = (force_k < 0) ? int'($urandom_range(0, 3)) : force_k;
            q.push_back(o);
        end
        if (want_i) begin
            o.is_i = 1'b1; o.wr = 1'b0; o.addr = ia; o.wdata = '0;
            o.k = (force_k < 0) ? int'($urandom_range(0, 3)) : force_k;
            q.push_back(o);
        end
        if (q.size() == 0) begin
            tick();
            check_quiet("idle_quiet");
            return;
        end
        for (int n = 0; n < q.size(); n++) begin
            o = q[n];
            if (n > 0) begin
                tick();                        // IDLE cycle between accesses
                check_quiet("gap_quiet");
            end
            rd = '0;
            for (int j = 0; j <= o.k; j++) begin
                tick();
                check("strobe", {60'd0, ramREN, ramWEN, ihit, dhit},
                      {60'd0, !o.wr, o.wr, 2'b00});
                check("ramaddr", 64'(ramaddr), 64'(o.addr));
                if (o.wr) check("ramstore", 64'(ramstore), 64'(o.wdata));
                ramrdy  = (j == o.k);
                rd      = $urandom;
                ramload = rd;
                // Request inputs must be ignored once the access is latched.
                if (o.is_i) begin
                    iaddr = $urandom;
                end else begin
                    daddr  = $urandom;
                    dstore = $urandom;
                end
            end
            if (o.is_i) exp_iload = rd;
            else if (!o.wr) exp_dload = rd;
            tick();                            // response cycle
            check("hit", {60'd0, ramREN, ramWEN, ihit, dhit},
                  {60'd0, 2'b00, o.is_i, !o.is_i});
            check("iload", 64'(iload), 64'(exp_iload));
            check("dload", 64'(dload), 64'(exp_dload));
            check("err", 64'(err), 64'd0);
            ramrdy  = 1'($urandom_range(0, 1));   // ignored outside access
            ramload = $urandom;
            if (o.is_i) begin
                iREN = 1'b0;
            end else begin
                dREN = 1'b0;
                dWEN = 1'b0;
            end
        end
        tick();                                // back in IDLE, nothing pending
        check_quiet("post_quiet");
    endtask

    initial begin
        int kind;
        RST = 1'b1;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramrdy = 1'b0;

        // Reset state.
        #12;
        check_quiet("rst_strobes");
        check("rst_err", 64'(err), 64'd0);
        check("rst_iload", 64'(iload), 64'd0);
        check("rst_dload", 64'(dload), 64'd0);
        check("rst_ramaddr", 64'(ramaddr), 64'd0);
        check("rst_ramstore", 64'(ramstore), 64'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Reset in the middle of a data access.
        dREN = 1'b1; daddr = 32'h0000_0080;
        tick();
        check("midop_ren", 64'(ramREN), 64'd1);
        RST = 1'b1;
        #1;
        check_quiet("midop_rst_quiet");
        check("midop_rst_addr", 64'(ramaddr), 64'd0);
        @(negedge CLK);
        RST  = 1'b0;
        dREN = 1'b0;
        ramrdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_quiet("midop_after");
        end
        ramrdy = 1'b0;

        // Directed: fetch with two wait cycles; contention; write; read+write.
        run_request(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 2);
        check("fetch_iload", 64'(iload), 64'(exp_iload));
        run_request(1'b1, 1'b1, 1'b0, 32'h40, 32'h200, 32'h0, 0);
        run_request(1'b0, 1'b0, 1'b1, 32'h0, 32'h300, 32'hDEAD_BEEF, 0);
        run_request(1'b0, 1'b1, 1'b1, 32'h0, 32'h304, 32'h1234_5678, 1);

        // Randomized traffic.
        repeat (80) begin
            kind = int'($urandom_range(0, 6));
            case (kind)
                0: run_request(1'b1, 1'b0, 1'b0, $urandom, $urandom, $urandom, -1);
                1: run_request(1'b0, 1'b1, 1'b0, $urandom, $urandom, $urandom, -1);
                2: run_request(1'b0, 1'b0, 1'b1, $urandom, $urandom, $urandom, -1);
                3: run_request(1'b0, 1'b1, 1'b1, $urandom, $urandom, $urandom, -1);
                4: run_request(1'b1, 1'b1, 1'b0, $urandom, $urandom, $urandom, -1);
                5: run_request(1'b1, 1'b0, 1'b1, $urandom, $urandom, $urandom, -1);
                default: run_request(1'b0, 1'b0, 1'b0, $urandom, $urandom, $urandom, -1);
            endcase
        end

        // RAM never answers.
        dREN = 1'b1; dWEN = 1'b0; daddr = 32'h0000_0400;
        ramrdy = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int c = 0; c < TO; c++) begin
            tick();
            check("to_wait", {60'd0, ramREN, ramWEN, ihit, dhit}, 64'b1000);
        end
        tick();
        check("to_hit", {60'd0, ramREN, ramWEN, ihit, dhit}, 64'b0001);
        check("to_dload", 64'(dload), 64'(32'hFFFF_FFFF));
        check("to_err", 64'(err), 64'd1);
        dREN = 1'b0;
        tick();
        tick();
        check("to_err_sticky", 64'(err), 64'd1);
        check_quiet("to_after");
`else
        for (int c = 0; c < TO + 16; c++) begin
            tick();
            check("wait_forever", {60'd0, ramREN, ramWEN, ihit, dhit}, 64'b1000);
        end
        ramrdy  = 1'b1;
        ramload = 32'hCAFE_F00D;
        tick();
        check("late_hit", {60'd0, ramREN, ramWEN, ihit, dhit}, 64'b0001);
        check("late_dload", 64'(dload), 64'(32'hCAFE_F00D));
        check("late_err", 64'(err), 64'd0);
        dREN   = 1'b0;
        ramrdy = 1'b0;
        tick();
        check_quiet("late_after");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
